// File: rtl/output_arbiter_pkg.sv
// Shared types and constants for the output_arbiter slice.
// Define OUTPUT_ARB_CHECKSUM_EN to add the trailing XOR checksum byte and its CSUM state.
package output_arb_pkg;

    localparam int LEN_W = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ID,
        LEN,
`ifdef OUTPUT_ARB_CHECKSUM_EN
        PAYLOAD,
        CSUM
`else
        PAYLOAD
`endif
    } arb_state_t;

endpackage

// File: rtl/output_arbiter_if.sv
// Request/payload bundle from the result producers plus the output FIFO write port.
// slave is the arbiter's view; master is the producers' and FIFO's view.
interface output_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import output_arb_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [LEN_W*NUM_REQ-1:0] req_len;
    logic [8*NUM_REQ-1:0]     req_data;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     out_set;
    logic [7:0]               out_data;
    logic                     out_full;

    modport master (
        output req, req_len, req_data, req_valid, out_full,
        input  req_ready, gnt, busy, out_set, out_data
    );

    modport slave (
        input  req, req_len, req_data, req_valid, out_full,
        output req_ready, gnt, busy, out_set, out_data
    );

endinterface

// File: rtl/output_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SRC_W-1:0]   idx_o
);

    logic             found;
    logic [SRC_W-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = SRC_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                idx_o      = pos;
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Round-robin packet scheduler framing sync/ID/length/payload onto the output FIFO.
// Define OUTPUT_ARB_CHECKSUM_EN to append the XOR checksum of ID, LEN and payload.
module output_arbiter
    import output_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input logic             clk,
    input logic             rst_n,
    output_arbiter_if.slave arb_if
);

`ifdef OUTPUT_ARB_CHECKSUM_EN
    localparam arb_state_t TAIL_STATE = CSUM;
    logic [7:0] csum_q;
`else
    localparam arb_state_t TAIL_STATE = IDLE;
`endif

    arb_state_t         state_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   rr_ptr_d;
    logic [SRC_W-1:0]   winner_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   cnt_d;
    logic [NUM_REQ-1:0] pickGnt;
    logic [SRC_W-1:0]   pickIdx;
    logic [LEN_W-1:0]   pickLen;
    logic [7:0]         selData;
    logic               selValid;
    logic               outSet;
    logic [7:0]         outData;
    logic [NUM_REQ-1:0] readyVec;
    logic [NUM_REQ-1:0] gntVec;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_i (arb_if.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pickGnt),
        .idx_o (pickIdx)
    );

    assign rr_ptr_d = (pickIdx == SRC_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
    assign cnt_d    = cnt_q + 8'd1;

    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        pickLen  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == winner_q) begin
                selData  = arb_if.req_data[i*8 +: 8];
                selValid = arb_if.req_valid[i];
            end
            if (SRC_W'(i) == pickIdx) begin
                pickLen = arb_if.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Strobe is gated by out_full everywhere, so each out_set is a committed write.
    always_comb begin
        outSet   = 1'b0;
        outData  = '0;
        readyVec = '0;
        gntVec   = '0;
        case (state_q)
            IDLE:    gntVec = rst_n ? pickGnt : '0;
            SYNC:    begin outSet = !arb_if.out_full; outData = SYNC_BYTE; end
            ID:      begin outSet = !arb_if.out_full; outData = 8'(winner_q); end
            LEN:     begin outSet = !arb_if.out_full; outData = len_q; end
            PAYLOAD: begin
                outSet  = selValid && !arb_if.out_full;
                outData = selData;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (SRC_W'(i) == winner_q) readyVec[i] = !arb_if.out_full;
                end
            end
`ifdef OUTPUT_ARB_CHECKSUM_EN
            CSUM:    begin outSet = !arb_if.out_full; outData = csum_q; end
`endif
            default: ;
        endcase
    end

    assign arb_if.gnt       = gntVec;
    assign arb_if.req_ready = readyVec;
    assign arb_if.out_set   = outSet;
    assign arb_if.out_data  = outData;
    assign arb_if.busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
`ifdef OUTPUT_ARB_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (|arb_if.req) begin
                    winner_q <= pickIdx;
                    rr_ptr_q <= rr_ptr_d;
                    len_q    <= pickLen;
                    cnt_q    <= '0;
                    state_q  <= SYNC;
                end
                SYNC: if (outSet) state_q <= ID;
                ID:   if (outSet) state_q <= LEN;
                LEN:  if (outSet) state_q <= (len_q != '0) ? PAYLOAD : TAIL_STATE;
                PAYLOAD: if (outSet) begin
                    cnt_q <= cnt_d;
                    if (cnt_d == len_q) state_q <= TAIL_STATE;
                end
`ifdef OUTPUT_ARB_CHECKSUM_EN
                CSUM: if (outSet) state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
`ifdef OUTPUT_ARB_CHECKSUM_EN
            // Accumulator restarts every arbitration cycle and folds in ID, LEN and payload.
            if (state_q == IDLE) begin
                csum_q <= '0;
            end else if (outSet && (state_q inside {ID, LEN, PAYLOAD})) begin
                csum_q <= csum_q ^ outData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: behavioural packet-stream model plus directed cases.
// Works with and without OUTPUT_ARB_CHECKSUM_EN defined.
module tb_output_arbiter;
    import output_arb_pkg::*;

    localparam int N = 4;
`ifdef OUTPUT_ARB_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    output_arbiter_if #(.NUM_REQ(N)) arbIf ();

    output_arbiter #(.NUM_REQ(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (arbIf)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleCount  = 0;

    logic [7:0] pktMem [N][256];
    int         pktLen [N];
    int         payIdx [N];
    logic [N-1:0] validHold  = '0;
    logic [N-1:0] autoRepeat = '0;
    logic         fullForce  = 1'b0;
    bit           randomOn   = 1'b0;

    logic [7:0] stage[$];
    logic [7:0] expList[$];
    logic [7:0] wrLog[$];
    int         gntLog[$];
    int         gntCyc[$];
    logic       setSeen   = 1'b0;
    logic       readySeen = 1'b0;

    // Reference model: a queue of the bytes the current packet must produce.
    logic [7:0] expQ[$];
    bit         mBusy = 1'b0;
    int         mPtr  = 0;
    int         mWin  = 0;
    int         mPos  = 0;
    int         mLen  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL timeout_%s: wait expired at cycle %0d", name, cycleCount);
    endtask

    always @(negedge clk) begin : compareProc
        logic [N-1:0] expGnt;
        logic [N-1:0] expReady;
        logic         expSet;
        bit           inPay;
        logic [7:0]   x;
        int           j;
        cycleCount++;
        setSeen   = setSeen | arbIf.out_set;
        readySeen = readySeen | (|arbIf.req_ready);
        if (!rst_n) begin
            checkOutput("resetOutputs", 32'({arbIf.gnt, arbIf.req_ready, arbIf.busy,
                                              arbIf.out_set, arbIf.out_data}), 32'd0);
            mBusy = 1'b0;
            mPtr  = 0;
            expQ.delete();
        end else if (!mBusy) begin
            expGnt = '0;
            for (int k = 0; k < N; k++) begin
                j = (mPtr + k) % N;
                if (expGnt == '0 && ((arbIf.req >> j) & N'(1)) != '0) begin
                    expGnt = N'(1) << j;
                    mWin   = j;
                end
            end
            checkOutput("gnt", 32'(arbIf.gnt), 32'(expGnt));
            checkOutput("idleBusySet", 32'({arbIf.busy, arbIf.out_set}), 32'd0);
            if (expGnt != '0) begin
                mLen  = pktLen[mWin];
                mPtr  = (mWin + 1) % N;
                mPos  = 0;
                mBusy = 1'b1;
                expQ.delete();
                expQ.push_back(SYNC_BYTE);
                expQ.push_back(8'(mWin));
                expQ.push_back(8'(mLen));
                x = 8'(mWin) ^ 8'(mLen);
                for (int b = 0; b < mLen; b++) begin
                    expQ.push_back(pktMem[mWin][b]);
                    x = x ^ pktMem[mWin][b];
                end
                if (CS == 1) expQ.push_back(x);
                gntLog.push_back(mWin);
                gntCyc.push_back(cycleCount);
            end
        end else begin
            inPay    = (mPos >= 3) && (mPos < 3 + mLen);
            expSet   = inPay ? ((((arbIf.req_valid >> mWin) & N'(1)) != '0) && !arbIf.out_full)
                             : !arbIf.out_full;
            expReady = (inPay && !arbIf.out_full) ? (N'(1) << mWin) : '0;
            checkOutput("busyGnt", 32'({arbIf.busy, arbIf.gnt}), 32'({1'b1, N'(0)}));
            checkOutput("outSet", 32'(arbIf.out_set), 32'(expSet));
            checkOutput("reqReady", 32'(arbIf.req_ready), 32'(expReady));
            if (expSet) begin
                checkOutput("outData", 32'(arbIf.out_data), 32'(expQ[0]));
                wrLog.push_back(arbIf.out_data);
                void'(expQ.pop_front());
                mPos++;
                if (expQ.size() == 0) mBusy = 1'b0;
            end
        end
    end

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            bit has;
            has = payIdx[i] < pktLen[i];
            arbIf.req_data[i*8 +: 8] = has ? pktMem[i][payIdx[i]] : 8'h00;
            arbIf.req_valid[i] = has && !validHold[i] && (!randomOn || ($urandom_range(3) != 0));
        end
        arbIf.out_full = fullForce || (randomOn && ($urandom_range(4) == 0));
    endtask

    // One clock: capture handshakes/grants before the edge, update producers after it.
    task automatic cycle();
        logic [N-1:0] acc;
        logic [N-1:0] gr;
        @(negedge clk);
        #1;
        acc = arbIf.req_valid & arbIf.req_ready;
        gr  = arbIf.gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) payIdx[i]++;
            if (gr[i] && !autoRepeat[i]) arbIf.req[i] = 1'b0;
        end
        driveInputs();
    endtask

    task automatic startPacket(input int i);
        pktLen[i] = stage.size();
        for (int b = 0; b < stage.size(); b++) pktMem[i][b] = stage[b];
        payIdx[i] = 0;
        arbIf.req_len[i*8 +: 8] = 8'(stage.size());
        arbIf.req[i] = 1'b1;
        driveInputs();
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((mBusy || (arbIf.req != '0)) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) timeoutFail(name);
        cycle();
    endtask

    task automatic waitWrites(input int count, input int budget, input string name);
        int n;
        n = 0;
        while (wrLog.size() < count && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) timeoutFail(name);
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_count"}, 32'(wrLog.size()), 32'(expList.size()));
        for (int i = 0; i < expList.size() && i < wrLog.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), 32'(wrLog[i]), 32'(expList[i]));
        end
    endtask

    task automatic applyStimulus();
        int mark;
        int g0;
        int g1;
        int len;

        // Round-robin with every requester asking continuously (zero-length packets).
        mark = gntLog.size();
        stage.delete();
        autoRepeat = '1;
        for (int i = 0; i < N; i++) startPacket(i);
        for (int n = 0; n < 200 && gntLog.size() < mark + 5; n++) cycle();
        if (gntLog.size() < mark + 5) timeoutFail("rr");
        autoRepeat = '0;
        waitIdle(200, "rrDrain");
        for (int k = 0; k < 5 && mark + k < gntLog.size(); k++) begin
            checkOutput($sformatf("rrOrder[%0d]", k), 32'(gntLog[mark + k]), 32'(k % N));
            if (k > 0) begin
                checkOutput($sformatf("rrGap[%0d]", k),
                            32'(gntCyc[mark + k] - gntCyc[mark + k - 1]), 32'(3 + CS + 1));
            end
        end

        // Single requester, two payload bytes.
        wrLog.delete();
        stage = '{8'h11, 8'h22};
        startPacket(0);
        waitIdle(100, "single");
`ifdef OUTPUT_ARB_CHECKSUM_EN
        expList = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h31};
`else
        expList = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
`endif
        checkLog("single");

        // Zero-length packet never asks for payload.
        wrLog.delete();
        readySeen = 1'b0;
        stage.delete();
        startPacket(1);
        waitIdle(100, "zeroLen");
`ifdef OUTPUT_ARB_CHECKSUM_EN
        expList = '{8'hA5, 8'h01, 8'h00, 8'h01};
`else
        expList = '{8'hA5, 8'h01, 8'h00};
`endif
        checkLog("zeroLen");
        checkOutput("zeroLenReady", 32'(readySeen), 32'd0);

        // FIFO backpressure for five cycles in the middle of the payload.
        wrLog.delete();
        stage = '{8'h01, 8'h02, 8'h03, 8'h04};
        startPacket(3);
        waitWrites(5, 100, "bpStart");
        fullForce = 1'b1;
        driveInputs();
        setSeen   = 1'b0;
        readySeen = 1'b0;
        repeat (5) cycle();
        checkOutput("bpNoSet", 32'(setSeen), 32'd0);
        checkOutput("bpNoReady", 32'(readySeen), 32'd0);
        checkOutput("bpHeld", 32'(wrLog.size()), 32'd5);
        fullForce = 1'b0;
        driveInputs();
        waitIdle(100, "bp");
`ifdef OUTPUT_ARB_CHECKSUM_EN
        expList = '{8'hA5, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03};
`else
        expList = '{8'hA5, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
        checkLog("backpressure");

        // Source stall before the second payload byte.
        wrLog.delete();
        stage = '{8'h5A, 8'h6B, 8'h7C};
        startPacket(2);
        waitWrites(4, 100, "stallStart");
        validHold[2] = 1'b1;
        driveInputs();
        setSeen = 1'b0;
        repeat (3) cycle();
        checkOutput("stallNoSet", 32'(setSeen), 32'd0);
        checkOutput("stallHeld", 32'(wrLog.size()), 32'd4);
        validHold = '0;
        driveInputs();
        waitIdle(100, "stall");
`ifdef OUTPUT_ARB_CHECKSUM_EN
        expList = '{8'hA5, 8'h02, 8'h03, 8'h5A, 8'h6B, 8'h7C, 8'h4C};
`else
        expList = '{8'hA5, 8'h02, 8'h03, 8'h5A, 8'h6B, 8'h7C};
`endif
        checkLog("srcStall");

        // Reset in the middle of a payload, then req0 and req3 compete.
        wrLog.delete();
        stage = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        startPacket(1);
        waitWrites(6, 100, "rstStart");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstImmediate", 32'({arbIf.busy, arbIf.out_set, arbIf.out_data,
                                          arbIf.req_ready, arbIf.gnt}), 32'd0);
        arbIf.req = '0;
        for (int i = 0; i < N; i++) payIdx[i] = pktLen[i];
        stage = '{8'hC1};
        startPacket(0);
        startPacket(3);
        repeat (2) cycle();
        #2;
        rst_n = 1'b1;
        mark = gntLog.size();
        waitIdle(100, "postReset");
        g0 = (gntLog.size() > mark)     ? gntLog[mark]     : -1;
        g1 = (gntLog.size() > mark + 1) ? gntLog[mark + 1] : -1;
        checkOutput("postResetFirst", 32'(g0), 32'd0);
        checkOutput("postResetSecond", 32'(g1), 32'd3);

        // Maximum length under random source and FIFO stalls.
        wrLog.delete();
        randomOn = 1'b1;
        stage.delete();
        for (int b = 0; b < 255; b++) stage.push_back(8'($urandom_range(255)));
        startPacket(2);
        waitIdle(3000, "len255");
        checkOutput("len255Count", 32'(wrLog.size()), 32'(3 + 255 + CS));

        // Random traffic on all requesters.
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (!arbIf.req[i] && payIdx[i] >= pktLen[i] && $urandom_range(7) == 0) begin
                    stage.delete();
                    len = ($urandom_range(99) == 0) ? 40 : int'($urandom_range(6));
                    for (int b = 0; b < len; b++) stage.push_back(8'($urandom_range(255)));
                    startPacket(i);
                end
            end
        end
        randomOn = 1'b0;
        driveInputs();
        waitIdle(2000, "randomDrain");
    endtask

    initial begin
        rst_n           = 1'b0;
        arbIf.req       = '0;
        arbIf.req_len   = '0;
        arbIf.req_data  = '0;
        arbIf.req_valid = '0;
        arbIf.out_full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            pktLen[i] = 0;
            payIdx[i] = 0;
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("afterReset", 32'({arbIf.busy, arbIf.gnt, arbIf.out_set}), 32'd0);
        cycle();
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cycleCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
